arith_ctrl: RTL and testbench

ARITH_CTRL -- requirements
Module: arith_ctrl

---
 rtl/arith_ctrl_if.sv | 24 ++
 rtl/arith_ctrl.sv | 158 +++++++++++++++
 tb/tb_arith_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_ctrl_if.sv
// Byte-stream input and result-output handshake bundle for arith_ctrl.
// slave = the controller side, master = the producer/consumer environment.
interface arith_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;
  logic             out_z;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cout, out_z
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cout, out_z
  );
endinterface

// File: rtl/arith_ctrl.sv
// Sequencer feeding an external combinational arithmetic unit: command byte, A, B, one EXEC cycle, result handshake.
// Optional ARITH_CTRL_CHAIN_EN: command bit [3] reuses the last captured result as A and skips the A byte.
module arith_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  arith_ctrl_if.slave      bus,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic             au_s1,
  output logic             au_s0,
  output logic             au_cin,
  input  logic [WIDTH-1:0] au_d,
  input  logic             au_cout,
  input  logic             au_z,
  output logic [7:0]       op_count
);

  typedef enum logic [2:0] {
    S_CMD,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             s1_q, s1_d;
  logic             s0_q, s0_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_cout_q, out_cout_d;
  logic             out_z_q, out_z_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       op_count_q, op_count_d;
  logic             ready;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s1_d        = s1_q;
    s0_d        = s0_q;
    cin_d       = cin_q;
    out_data_d  = out_data_q;
    out_cout_d  = out_cout_q;
    out_z_d     = out_z_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
    ready       = 1'b0;

    unique case (state_q)
      S_CMD: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          s1_d  = bus.in_data[2];
          s0_d  = bus.in_data[1];
          cin_d = bus.in_data[0];
`ifdef ARITH_CTRL_CHAIN_EN
          if (bus.in_data[3]) begin
            a_d     = out_data_q;
            state_d = S_GET_B;
          end else begin
            state_d = S_GET_A;
          end
`else
          state_d = S_GET_A;
`endif
        end
      end

      S_GET_A: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.in_data;
          state_d = S_GET_B;
        end
      end

      S_GET_B: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          b_d     = bus.in_data;
          state_d = S_EXEC;
        end
      end

      // Operands settled during the previous edge; the unit's result is valid now.
      S_EXEC: begin
        out_data_d  = au_d;
        out_cout_d  = au_cout;
        out_z_d     = au_z;
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = S_CMD;
        end
      end

      default: state_d = S_CMD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CMD;
      a_q         <= '0;
      b_q         <= '0;
      s1_q        <= 1'b0;
      s0_q        <= 1'b0;
      cin_q       <= 1'b0;
      out_data_q  <= '0;
      out_cout_q  <= 1'b0;
      out_z_q     <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      cin_q       <= cin_d;
      out_data_q  <= out_data_d;
      out_cout_q  <= out_cout_d;
      out_z_q     <= out_z_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  // The state register already sits in CMD during reset; gating keeps in_ready low then.
  assign bus.in_ready  = ready && rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_z     = out_z_q;

  assign au_a     = a_q;
  assign au_b     = b_q;
  assign au_s1    = s1_q;
  assign au_s0    = s0_q;
  assign au_cin   = cin_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_arith_ctrl.sv
// Self-checking bench for arith_ctrl: directed byte sequences, stub arithmetic unit,
// scoreboard queue of expected results popped by an independent output monitor.
module tb_arith_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arith_ctrl_if #(.WIDTH(WIDTH)) bus ();

  logic [WIDTH-1:0] au_a, au_b, au_d;
  logic             au_s1, au_s0, au_cin, au_cout, au_z;
  logic [7:0]       op_count;

  logic [WIDTH-1:0] stub_d = '0;
  logic             stub_cout = 1'b0;
  logic             stub_z = 1'b0;
  assign au_d    = stub_d;
  assign au_cout = stub_cout;
  assign au_z    = stub_z;

  arith_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .au_a     (au_a),
    .au_b     (au_b),
    .au_s1    (au_s1),
    .au_s0    (au_s0),
    .au_cin   (au_cin),
    .au_d     (au_d),
    .au_cout  (au_cout),
    .au_z     (au_z),
    .op_count (op_count)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             cout;
    logic             z;
  } resp_t;

  resp_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge whenever both are high here.
  always @(negedge clk) begin
    resp_t r;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        check("out_data", bus.out_data, r.d);
        check("out_cout", bus.out_cout, r.cout);
        check("out_z", bus.out_z, r.z);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Inputs change at posedge+2; DUT outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic check_operands(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b);
    check("au_a", au_a, a);
    check("au_b", au_b, b);
    check("au_s1", au_s1, cmd[2]);
    check("au_s0", au_s0, cmd[1]);
    check("au_cin", au_cin, cmd[0]);
  endtask

  // Called right after the B byte transferred: EXEC for one cycle, then result held in RESP.
  task automatic finish_op(input logic [7:0] d, input logic cout, input logic z, input int hold);
    exp_q.push_back('{d: d, cout: cout, z: z});
    @(negedge clk);
    check("exec_out_valid_low", bus.out_valid, 1'b0);
    check("exec_in_ready_low", bus.in_ready, 1'b0);
    @(negedge clk);
    check("latency_out_valid", bus.out_valid, 1'b1);
    step();
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_out_valid", bus.out_valid, 1'b1);
        check("hold_out_data", bus.out_data, d);
        check("hold_in_ready", bus.in_ready, 1'b0);
        check("hold_op_count", op_count, exp_count);
      end
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    check("op_count", op_count, exp_count);
    check("post_out_valid", bus.out_valid, 1'b0);
  endtask

  task automatic run_op(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic cout, input logic z, input int hold);
    stub_d    = d;
    stub_cout = cout;
    stub_z    = z;
    send_byte(cmd);
    send_byte(a);
    send_byte(b);
    check_operands(cmd, a, b);
    finish_op(d, cout, z, hold);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"}, bus.out_data, 8'h00);
    check({tag, "_out_cout"}, bus.out_cout, 1'b0);
    check({tag, "_out_z"}, bus.out_z, 1'b0);
    check_operands(8'h00, 8'h00, 8'h00);
    check({tag, "_op_count"}, op_count, 8'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    reset_check("reset");
    step();
    rst_n = 1'b1;
    step();

    // Basic add-style vector: 35, 25 -> stub result 60.
    run_op(8'h00, 8'd35, 8'd25, 8'd60, 1'b0, 1'b0, 0);

    // Consumer stalls for 5 cycles while junk bytes are offered.
    run_op(8'h04, 8'd100, 8'd3, 8'h67, 1'b0, 1'b0, 5);

    // All select bits set, zero result with carry.
    run_op(8'h07, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 0);

    // Upper command bits (bit 3 clear) do not disturb the select fields.
    run_op(8'hF5, 8'h80, 8'h7F, 8'hC3, 1'b0, 1'b0, 0);

    // out_ready with nothing pending changes nothing.
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready_out_valid", bus.out_valid, 1'b0);
      check("idle_ready_op_count", op_count, exp_count);
    end
    step();
    bus.out_ready = 1'b0;

    // Chain command after a result of 60.
    run_op(8'h00, 8'd35, 8'd25, 8'd60, 1'b0, 1'b0, 0);
`ifdef ARITH_CTRL_CHAIN_EN
    stub_d = 8'd65; stub_cout = 1'b0; stub_z = 1'b0;
    send_byte(8'h08);
    send_byte(8'd5);
    check_operands(8'h08, 8'd60, 8'd5);
    finish_op(8'd65, 1'b0, 1'b0, 0);
`else
    stub_d = 8'd12; stub_cout = 1'b0; stub_z = 1'b0;
    send_byte(8'h08);
    send_byte(8'd5);
    repeat (3) begin
      @(negedge clk);
      check("nochain_waits_out_valid", bus.out_valid, 1'b0);
      check("nochain_waits_in_ready", bus.in_ready, 1'b1);
      check("nochain_au_a", au_a, 8'd5);
    end
    step();
    send_byte(8'd7);
    check_operands(8'h08, 8'd5, 8'd7);
    finish_op(8'd12, 1'b0, 1'b0, 0);
`endif

    // Reset after only the A byte: everything clears, next sequence starts fresh.
    send_byte(8'h07);
    send_byte(8'd99);
    #1;
    rst_n = 1'b0;
    #1;
    reset_check("midop_reset");
    exp_count = 0;
    step();
    rst_n = 1'b1;
    step();
    run_op(8'h02, 8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 0);

    // 256 further operations carry op_count through 255 -> 0.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a, b;
      a = 8'(i);
      b = 8'(255 - i);
      run_op(8'(i % 8), a, b, a ^ b, 1'(i % 2), 1'((i % 3) == 0), 0);
      if (exp_count == 0) check("wrap_op_count_zero", op_count, 8'd0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
